// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a
// DEPTH-entry prefetch FIFO that presents {pc, inst} to decode.
module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   // instruction memory side
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   // redirect and decode handshake
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   input  logic        stall_i,
   output logic        inst_valid_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_DROP
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   state_t            state_q, state_d;
   logic [31:0]       fetch_pc_q, fetch_pc_d;
   logic [31:0]       drop_addr_q, drop_addr_d;
   logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]  count_q, count_d, count_after_deq;
   entry_t            fifo_q [DEPTH];
   entry_t            head;
   logic              enq, deq;

   // The low two bits of a redirect target are forced to zero (word aligned).
   logic unused_flush_lsbs;
   assign unused_flush_lsbs = ^flush_pc_i[1:0];

   // ---------------------------------------------------------------- datapath
   assign inst_valid_o = (count_q != '0);
   assign head         = fifo_q[rd_ptr_q];
   assign pc_o         = inst_valid_o ? head.pc   : 32'h0;
   assign inst_o       = inst_valid_o ? head.inst : 32'h0;

   assign imem_req_o   = (state_q != ST_IDLE);
   assign imem_addr_o  = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

   // Flush wins over both queue operations in the same cycle.
   assign deq = inst_valid_o & ~stall_i & ~flush_i;
   assign enq = (state_q == ST_REQ) & imem_ack_i & ~flush_i;

   assign count_after_deq = count_q - {{(CNT_W-1){1'b0}}, deq};
   assign count_d         = flush_i ? '0 : count_after_deq + {{(CNT_W-1){1'b0}}, enq};

   // ------------------------------------------------------------ next state
   // NOTE: every signal written here gets its default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (!flush_i && (count_after_deq < DEPTH_C))
               state_d = ST_REQ;
         end
         ST_REQ: begin
            if (imem_ack_i) begin
               if (flush_i) begin
                  state_d = ST_IDLE;
               end else begin
                  fetch_pc_d = fetch_pc_q + 32'd4;
                  state_d    = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
               end
            end else if (flush_i) begin
               // Bus address must stay put until the abandoned read returns.
               state_d     = ST_DROP;
               drop_addr_d = fetch_pc_q;
            end
         end
         ST_DROP: begin
            if (imem_ack_i)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (flush_i)
         fetch_pc_d = {flush_pc_i[31:2], 2'b00};
   end

   // ------------------------------------------------------------- registers
   // NOTE: state uses non-blocking assignments so every register samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= RESET_PC;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
         count_q     <= count_d;
         if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
      end
   end

   // NOTE: the FIFO storage has no reset; count_q alone decides validity and
   // the outputs are masked to zero while the buffer is empty.
   always_ff @(posedge clk) begin
      if (enq)
         fifo_q[wr_ptr_q] <= '{pc: imem_addr_o, inst: imem_data_i};
   end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 The block SHALL provide parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL provide parameter DEPTH, default 4, which is the number of prefetch buffer entries; legal values are powers of two, 2 or greater.
REQ-003 The block SHALL provide clk, input, 1 bit, the system clock; all state changes on the rising edge.
REQ-004 The block SHALL provide rst, input, 1 bit, reset, synchronous, active-high.
REQ-005 The block SHALL provide imem_req_o, output, 1 bit, instruction memory read request.
REQ-006 The block SHALL provide imem_addr_o, output, 32 bits, the word address of the request.
REQ-007 The block SHALL provide imem_ack_i, input, 1 bit, read data valid; it is sampled only while imem_req_o=1.
REQ-008 The block SHALL provide imem_data_i, input, 32 bits, the instruction word, valid when imem_ack_i=1.
REQ-009 The block SHALL provide flush_i, input, 1 bit, redirect request (branch or exception).
REQ-010 The block SHALL provide flush_pc_i, input, 32 bits, the redirect target.
REQ-011 The block SHALL provide stall_i, input, 1 bit; when 1, the decode stage is not accepting an instruction this cycle.
REQ-012 The block SHALL provide inst_valid_o, output, 1 bit; pc_o/inst_o hold a valid instruction.
REQ-013 The block SHALL provide pc_o, output, 32 bits, the address of the instruction presented to decode.
REQ-014 The block SHALL provide inst_o, output, 32 bits, the instruction word presented to decode.

Function
REQ-015 The block SHALL implement a 3-state FSM: IDLE (no request outstanding), REQ (request outstanding), DROP (request outstanding whose data will be discarded).
REQ-016 The block SHALL drive imem_req_o=1 if and only if the state is REQ or DROP.
REQ-017 The block SHALL hold imem_addr_o stable from request assertion until the edge at which imem_ack_i=1 is sampled.
REQ-018 The block SHALL drive imem_addr_o=fetch_pc in REQ, and the pre-flush address in DROP.
REQ-019 IDLE->REQ SHALL occur at an edge where flush_i=0 and count<DEPTH; count is the number of buffered entries after that edge's dequeue.
REQ-020 REQ with imem_ack_i=1 and flush_i=0 SHALL enqueue {imem_addr_o, imem_data_i} and set fetch_pc to fetch_pc+4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 After the REQ enqueue, the FSM SHALL stay in REQ (back-to-back) if the new count<DEPTH, else go to IDLE.
REQ-022 REQ with imem_ack_i=0 SHALL remain in REQ.
REQ-023 The block SHALL keep at most one request outstanding; count+outstanding SHALL never exceed DEPTH, so enqueue never meets a full buffer.
REQ-024 The block SHALL drive inst_valid_o=1 if and only if count>0; pc_o/inst_o SHALL be the head entry, or 32'h0 when empty (inst_o=0 is a NOP).
REQ-025 The block SHALL dequeue the head at an edge where inst_valid_o=1, stall_i=0 and flush_i=0.
REQ-026 A simultaneous enqueue and dequeue SHALL leave count unchanged, with FIFO order preserved.
REQ-027 Flush (flush_i=1 at an edge) SHALL empty the buffer, suppress that edge's dequeue, and set fetch_pc to {flush_pc_i[31:2], 2'b00}.
REQ-028 Flush in IDLE SHALL remain in IDLE; the request to the new target SHALL assert one cycle later.
REQ-029 Flush in REQ with imem_ack_i=1 SHALL discard the returned data and go to IDLE.
REQ-030 Flush in REQ with imem_ack_i=0 SHALL go to DROP.
REQ-031 DROP with imem_ack_i=1 SHALL discard the data and go to IDLE; DROP with imem_ack_i=0 SHALL remain in DROP.
REQ-032 Flush in DROP SHALL update fetch_pc only and remain in DROP.
REQ-033 Flush SHALL take priority over enqueue, dequeue and stall in the same cycle.
REQ-034 inst_valid_o SHALL be 0 in the cycle after any flush.
REQ-035 An instruction SHALL appear on inst_valid_o no earlier than the cycle after its ack (minimum fetch-to-decode latency 1 cycle after ack).

Reset
REQ-036 At an edge with rst=1, the block SHALL go to state IDLE, set count=0, empty the buffer and set fetch_pc=RESET_PC.
REQ-037 After reset, the outputs SHALL be imem_req_o=0, imem_addr_o=RESET_PC, inst_valid_o=0, pc_o=0 and inst_o=0.
REQ-038 rst SHALL override flush_i, imem_ack_i and stall_i.
REQ-039 rst during an outstanding request SHALL drop that request; the memory side is reset by the same rst.
REQ-040 The first request after reset SHALL assert in the cycle after rst deasserts.

Verification
REQ-041 Bench: release rst, memory acks every cycle, stall_i=0 -> pc_o sequence 0x0, 0x4, 0x8, 0xC with matching data; steady throughput of one instruction per cycle.
REQ-042 Bench: stall_i=1 held for 10 cycles -> count saturates at 4 and imem_req_o=0; on stall release, entries drain in order 0x0..0xC with no loss or duplication.
REQ-043 Bench: flush_i=1 with flush_pc_i=0x100 while a request to 0x8 is pending and the ack arrives 3 cycles later -> the 0x8 data is discarded; the next request is to 0x100, and the next pc_o is 0x100.
REQ-044 Bench: flush_i=1 on the same edge as an ack and a dequeue -> the buffer is empty, inst_valid_o=0 the next cycle, and the acked data never appears.
REQ-045 Bench: RESET_PC=32'hFFFF_FFF8 -> pc_o sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-046 Bench: rst asserted while in REQ with count=2 -> the next cycle shows imem_req_o=0 and inst_valid_o=0, and fetching resumes from RESET_PC.
